key_fifo_writer: RTL
====================

// Module: key_fifo_writer
// PURPOSE
//  Upstream producer for the hash pipeline. Accepts a key as a byte stream
//  (valid/ready/last), packs it MSB-first into FIFOWIDTH-bit words and writes
//  them to the key FIFO. Once the key's last word is written, it writes the
//  byte length to the key-length FIFO. This is the writer side of the
//  iKey/iKeyLen FIFO pair that HashTop reads.
// PARAMETERS
//  FIFOWIDTH   128  key FIFO word width in bits; must be a multiple of 8 (BPW = FIFOWIDTH/8)
//  MAX_KEYLEN  64   maximum stored key bytes; multiple of BPW, <= 255
// PORTS
//  clk              in   1          single clock, all logic on posedge
//  rst              in   1          synchronous reset, active-high
//  iKeyByte         in   8          key byte
//  iKeyValid        in   1          iKeyByte is valid
//  iKeyLast         in   1          this byte is the final byte of the key
//  oKeyReady        out  1          byte accepted when iKeyValid && oKeyReady
//  oWrKeyFifo_en    out  1          key FIFO write enable (1-cycle pulse)
//  oKey             out  FIFOWIDTH  key word; valid while oWrKeyFifo_en=1
//  iWrKeyFull       in   1          key FIFO full
//  oWrKeyLenFifo_en out  1          key-length FIFO write enable (1-cycle pulse)
//  oKeyLen          out  8          key length in bytes; valid while oWrKeyLenFifo_en=1
//  iWrKeyLenFull    in   1          key-length FIFO full
//  oKeyErr          out  1          1-cycle pulse: key was truncated to MAX_KEYLEN
//  oKeyCount        out  16         number of keys completed (wraps at 0xFFFF->0)
// BEHAVIOUR
//  Reset: state=COLLECT. Word register, byte lane counter, length counter,
//   oKeyLen, oKeyCount = 0. oKeyReady=1. Enables and oKeyErr = 0.
//   Reset mid-key drops the partial key; nothing is written for it.
//  Packing: byte k of a word goes to oKey[FIFOWIDTH-1-8k -: 8]. Unfilled lanes are 0.
//   The word register clears after each write.
//  States:
//   COLLECT: oKeyReady=1. On each accepted byte: store it in the current lane,
//    lane++, len++. Go to WR_WORD if the lane reaches BPW or iKeyLast=1.
//    The last-seen flag is latched.
//   WR_WORD: oKeyReady=0. When iWrKeyFull=0: oWrKeyFifo_en=1 for 1 cycle, then
//    - last seen -> WR_LEN
//    - len==MAX_KEYLEN -> DROP
//    - otherwise -> COLLECT (lane=0).
//    While full: hold the word and the state, no enable.
//   DROP: oKeyReady=1. Accepted bytes are discarded and len stays MAX_KEYLEN.
//    The truncation flag is set. On an accepted byte with iKeyLast=1 -> WR_LEN.
//   WR_LEN: oKeyReady=0. When iWrKeyLenFull=0: oWrKeyLenFifo_en=1 and
//    oKeyLen=len. oKeyErr=1 in the same cycle if the truncation flag is set.
//    oKeyCount++. Clear len, lane, flags. Next state COLLECT.
//  Latency: last byte accepted in cycle N -> key write in N+1 -> length write
//   in N+2 -> ready again in N+3 (with no full stalls).
//  Minimum key length is 1: every beat carries a byte. Length never exceeds
//   MAX_KEYLEN. The key word is always written before its length, so the
//   reader can never see a length ahead of its words.
//  iKeyLast is ignored when iKeyValid=0. The two write enables are never
//   asserted in the same cycle.
// TESTING
//  T1 5-byte key 01..05, FIFOs not full -> 1 write,
//     oKey=0x0102030405 followed by 22 zero nibbles; then oKeyLen=0x05; oKeyCount=1.
//  T2 16-byte key 01..10 -> 1 word 0x0102..10, len 0x10.
//     Next key, 17 bytes -> 2 words, the second = 0x11 followed by 30 zero nibbles; len 0x11.
//  T3 iWrKeyFull=1 for 10 cycles in WR_WORD -> no enable and oKey stable;
//     a single write in the first cycle full=0.
//  T4 70-byte key -> 4 words written; bytes 65-70 are accepted and dropped;
//     oKeyLen=0x40 with a 1-cycle oKeyErr.
//  T5 rst pulsed after 7 bytes -> no FIFO writes. Next 3-byte key AA BB CC ->
//     word 0xAABBCC followed by 26 zero nibbles, len 0x03, oKeyCount=1.
//  T6 Two back-to-back 4-byte keys with iWrKeyLenFull=1 for 5 cycles ->
//     ready stays low until the first length is written; order is W1,L1,W2,L2.

Source files
------------

// File: rtl/key_fifo_writer.sv
// key_fifo_writer: packs a valid/ready byte stream MSB-first into key FIFO words, then writes the key length.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   iKeyByte/iKeyValid/iKeyLast/oKeyReady   incoming key byte stream
//   oWrKeyFifo_en/oKey/iWrKeyFull           key FIFO write side
//   oWrKeyLenFifo_en/oKeyLen/iWrKeyLenFull  key-length FIFO write side
//   oKeyErr                   pulses with the length write of a truncated key
//   oKeyCount                 number of keys completed, wraps
module key_fifo_writer #(
  parameter int FIFOWIDTH  = 128,
  parameter int MAX_KEYLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           iKeyByte,
  input  logic                 iKeyValid,
  input  logic                 iKeyLast,
  output logic                 oKeyReady,
  output logic                 oWrKeyFifo_en,
  output logic [FIFOWIDTH-1:0] oKey,
  input  logic                 iWrKeyFull,
  output logic                 oWrKeyLenFifo_en,
  output logic [7:0]           oKeyLen,
  input  logic                 iWrKeyLenFull,
  output logic                 oKeyErr,
  output logic [15:0]          oKeyCount
);
  localparam int BPW = FIFOWIDTH / 8;
  localparam int LW  = $clog2(BPW + 1);
  localparam logic [LW-1:0] BPW_L = LW'(BPW);
  localparam logic [7:0]    MAX_L = 8'(MAX_KEYLEN);

  typedef enum logic [1:0] {COLLECT, WR_WORD, DROP, WR_LEN} state_t;

  state_t               state_q, state_d;
  logic [FIFOWIDTH-1:0] word_q, word_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [7:0]           len_q, len_d;
  logic                 last_q, last_d;
  logic                 trunc_q, trunc_d;
  logic [15:0]          count_q, count_d;
  logic                 ready, acc, key_wr, len_wr;
  logic [LW-1:0]        lane_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q  <= '0;
      lane_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    ready    = state_q == COLLECT || state_q == DROP;
    acc      = iKeyValid && ready;
    key_wr   = state_q == WR_WORD && !iWrKeyFull;
    len_wr   = state_q == WR_LEN && !iWrKeyLenFull;
    lane_inc = lane_q + LW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: state_d = (acc && (lane_inc == BPW_L || iKeyLast)) ? WR_WORD : COLLECT;
      WR_WORD: state_d = !key_wr ? WR_WORD : last_q ? WR_LEN : (len_q == MAX_L) ? DROP : COLLECT;
      DROP:    state_d = (acc && iKeyLast) ? WR_LEN : DROP;
      default: state_d = len_wr ? COLLECT : WR_LEN;
    endcase
  end

  // Bytes land MSB-first: lane k occupies word[FIFOWIDTH-1-8k -: 8].
  always_comb begin
    word_d  = word_q;
    lane_d  = lane_q;
    len_d   = len_q;
    last_d  = last_q;
    trunc_d = trunc_q;
    count_d = count_q;
    if (state_q == COLLECT && acc) begin
      word_d = word_q | ({iKeyByte, {(FIFOWIDTH-8){1'b0}}} >> {lane_q, 3'b000});
      lane_d = lane_inc;
      len_d  = len_q + 8'd1;
      last_d = iKeyLast;
    end
    if (key_wr) begin
      word_d = '0;
      lane_d = '0;
    end
    if (state_q == DROP && acc) trunc_d = 1'b1;
    if (len_wr) begin
      len_d   = '0;
      lane_d  = '0;
      last_d  = 1'b0;
      trunc_d = 1'b0;
      count_d = count_q + 16'd1;
    end
  end

  always_comb begin
    oKeyReady        = ready;
    oWrKeyFifo_en    = key_wr;
    oKey             = word_q;
    oWrKeyLenFifo_en = len_wr;
    oKeyLen          = len_q;
    oKeyErr          = len_wr && trunc_q;
    oKeyCount        = count_q;
  end
endmodule
